// File: rtl/zbt_point_arbiter_pkg.sv
// Shared ZBT constants, arbiter state encoding and point record layout.
// The capture writer packs x/y/depth into one ZBT word with pt_pack().
package zbt_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;
    localparam int ZBT_LAT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } zbt_state_e;

    localparam int PT_X_LSB = 0;
    localparam int PT_X_W   = 12;
    localparam int PT_Y_LSB = 12;
    localparam int PT_Y_W   = 12;
    localparam int PT_D_LSB = 24;
    localparam int PT_D_W   = 12;

    function automatic logic [ZBT_DATA_W-1:0] pt_pack(input logic [PT_X_W-1:0] x,
                                                      input logic [PT_Y_W-1:0] y,
                                                      input logic [PT_D_W-1:0] d);
        logic [ZBT_DATA_W-1:0] r;
        r = '0;
        r[PT_X_LSB +: PT_X_W] = x;
        r[PT_Y_LSB +: PT_Y_W] = y;
        r[PT_D_LSB +: PT_D_W] = d;
        return r;
    endfunction

endpackage

// File: rtl/zbt_point_arbiter_if.sv
// Requester and ZBT-driver signals of the point arbiter in one bundle.
// slave = arbiter side; master = requesters plus the SRAM read-data return.
interface zbt_point_arbiter_if
    import zbt_pkg::*;
#(
    parameter int ADDR_W = ZBT_ADDR_W,
    parameter int DATA_W = ZBT_DATA_W
);
    logic              start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   wr_count;
    logic              done;
    logic              zbt_we;
    logic [ADDR_W-1:0] zbt_addr;
    logic [DATA_W-1:0] zbt_write_data;
    logic [DATA_W-1:0] zbt_read_data;

    modport master (
        output start, wr_valid, wr_data, rd_req, rd_addr, zbt_read_data,
        input  wr_ready, rd_ready, rd_valid, rd_data, wr_count, done,
               zbt_we, zbt_addr, zbt_write_data
    );

    modport slave (
        input  start, wr_valid, wr_data, rd_req, rd_addr, zbt_read_data,
        output wr_ready, rd_ready, rd_valid, rd_data, wr_count, done,
               zbt_we, zbt_addr, zbt_write_data
    );

endinterface

// File: rtl/zbt_point_arbiter_pipe_delay.sv
// Fixed-latency shift register; used to line operations up with the ZBT pipeline.
module zbt_pipe_delay
    import zbt_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = ZBT_LAT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/zbt_point_arbiter.sv
// Shares one ZBT port between the capture writer and the display reader,
// hiding the 2-cycle write-data / read-data pipeline from both.
module zbt_point_arbiter
    import zbt_pkg::*;
#(
    parameter int ADDR_W        = ZBT_ADDR_W,
    parameter int DATA_W        = ZBT_DATA_W,
    parameter int DEPTH         = 2**19,
    parameter int BASE_ADDR     = 0,
    parameter int MAX_RD_STREAK = 3
) (
    input  logic clk_i,
    input  logic reset_n_i,
    zbt_point_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_RD_STREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_RD_STREAK);
    localparam logic [ADDR_W:0]   LAST_IDX   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    zbt_state_e        state_q;
    logic [ADDR_W:0]   wr_count_q;
    logic              done_q;
    logic [SW-1:0]     streak_q, streak_d;

    logic              zbt_we_q;
    logic [ADDR_W-1:0] zbt_addr_q, zbt_addr_d;
    logic              rd_iss_q;
    logic [DATA_W-1:0] zbt_wdata_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              capturing, wr_waiting, force_wr;
    logic              rd_go, wr_rdy, wr_go;
    logic [DATA_W:0]   wop_dly;
    logic              rd_tag;

    // Reader wins unless the writer has already been starved MAX_RD_STREAK times.
    assign capturing  = (state_q == ST_CAPTURE);
    assign wr_waiting = bus.wr_valid && capturing;
    assign force_wr   = wr_waiting && (streak_q == STREAK_MAX);
    assign rd_go      = bus.rd_req && !force_wr;
    assign wr_rdy     = capturing && !bus.start && !rd_go;
    assign wr_go      = wr_rdy && bus.wr_valid;

    always_comb begin
        streak_d = streak_q;
        if (rd_go && wr_waiting) begin
            if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (wr_go || !wr_waiting) begin
            streak_d = '0;
        end
    end

    always_comb begin
        zbt_addr_d = zbt_addr_q;
        if (wr_go)      zbt_addr_d = BASE + wr_count_q[ADDR_W-1:0];
        else if (rd_go) zbt_addr_d = bus.rd_addr;
    end

    // Frame FSM; start always restarts the frame, even mid-capture.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            done_q     <= 1'b0;
        end else if (bus.start) begin
            state_q    <= ST_CAPTURE;
            wr_count_q <= '0;
            done_q     <= 1'b0;
        end else if (wr_go) begin
            wr_count_q <= wr_count_q + 1'b1;
            if (wr_count_q == LAST_IDX) begin
                state_q <= ST_FULL;
                done_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            streak_q   <= '0;
            zbt_we_q   <= 1'b0;
            zbt_addr_q <= '0;
            rd_iss_q   <= 1'b0;
        end else begin
            streak_q   <= streak_d;
            zbt_we_q   <= wr_go;
            zbt_addr_q <= zbt_addr_d;
            rd_iss_q   <= rd_go;
        end
    end

    // Write data enters at accept so it leaves the delay line one cycle
    // before the ZBT wants it on the bus.
    zbt_pipe_delay #(.W(DATA_W + 1), .DEPTH(ZBT_LAT)) u_wr_dly (
        .clk_i  (clk_i),
        .rst_ni (reset_n_i),
        .d_i    ({wr_go, bus.wr_data}),
        .q_o    (wop_dly)
    );

    // Read tag follows the issued address, landing on the data-return cycle.
    zbt_pipe_delay #(.W(1), .DEPTH(ZBT_LAT)) u_rd_dly (
        .clk_i  (clk_i),
        .rst_ni (reset_n_i),
        .d_i    (rd_iss_q),
        .q_o    (rd_tag)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            zbt_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (wop_dly[DATA_W]) zbt_wdata_q <= wop_dly[DATA_W-1:0];
            rd_valid_q <= rd_tag;
            if (rd_tag) rd_data_q <= bus.zbt_read_data;
        end
    end

    assign bus.wr_ready       = wr_rdy;
    assign bus.rd_ready       = rd_go;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.wr_count       = wr_count_q;
    assign bus.done           = done_q;
    assign bus.zbt_we         = zbt_we_q;
    assign bus.zbt_addr       = zbt_addr_q;
    assign bus.zbt_write_data = zbt_wdata_q;

endmodule

// File: tb/tb_zbt_point_arbiter.sv
// Scoreboard bench: grants predicted per cycle, ZBT/read results queued with due cycles.
module tb_zbt_point_arbiter;
    import zbt_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {int due; logic we; logic [18:0] addr;} aexp_t;
    typedef struct {int due; logic [35:0] d;} dexp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    aexp_t aq[$];
    dexp_t wq[$];
    dexp_t rq[$];
    logic [18:0] last_addr = '0;
    logic [35:0] last_wd = '0;

    int          m_st = 0;
    logic [19:0] m_cnt = '0;
    int          m_streak = 0;
    logic        g_rd, g_wacc;

    logic [18:0] ma1, ma2;

    zbt_point_arbiter_if #(.ADDR_W(19), .DATA_W(36)) bus ();

    zbt_point_arbiter #(.ADDR_W(19), .DATA_W(36), .DEPTH(DEPTH),
                        .BASE_ADDR(0), .MAX_RD_STREAK(3)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [35:0] rdfun(input logic [18:0] a);
        if (a == 19'h5) return 36'hABCDE0123;
        return {a[16:0], a} ^ 36'h5A5A5A5A5;
    endfunction

    // ZBT read model: data for the address issued in cycle n is presented in n+2.
    always @(posedge clk) begin
        ma1 <= bus.zbt_addr;
        ma2 <= ma1;
    end
    assign bus.zbt_read_data = rdfun(ma2);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        aexp_t a;
        dexp_t d;
        if (aq.size() > 0 && aq[0].due == cyc) begin
            a = aq.pop_front();
            chk("zbt_we", bus.zbt_we, a.we);
            chk("zbt_addr", bus.zbt_addr, a.addr);
            last_addr = a.addr;
        end else begin
            chk("idle_we", bus.zbt_we, 1'b0);
            chk("hold_addr", bus.zbt_addr, last_addr);
        end
        if (wq.size() > 0 && wq[0].due == cyc) begin
            d = wq.pop_front();
            chk("zbt_wdata", bus.zbt_write_data, d.d);
            last_wd = d.d;
        end else begin
            chk("hold_wdata", bus.zbt_write_data, last_wd);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            d = rq.pop_front();
            chk("rd_valid", bus.rd_valid, 1'b1);
            chk("rd_data", bus.rd_data, d.d);
        end else begin
            chk("rd_valid_idle", bus.rd_valid, 1'b0);
        end
    end

    task automatic tick(input logic s, input logic wv, input logic [35:0] wd,
                        input logic rqv, input logic [18:0] ra);
        logic cap, wait_w, frc, erd, ewr, aw;
        aexp_t a;
        dexp_t d;
        bus.start = s; bus.wr_valid = wv; bus.wr_data = wd;
        bus.rd_req = rqv; bus.rd_addr = ra;
        @(negedge clk);
        cap    = (m_st == 1);
        wait_w = wv && cap;
        frc    = wait_w && (m_streak == 3);
        erd    = rqv && !frc;
        ewr    = cap && !s && !erd;
        chk("rd_ready", bus.rd_ready, erd);
        chk("wr_ready", bus.wr_ready, ewr);
        chk("wr_count", bus.wr_count, m_cnt);
        chk("done", bus.done, m_st == 2);
        g_rd   = bus.rd_ready;
        g_wacc = bus.wr_ready && wv;
        aw = ewr && wv;
        if (aw) begin
            a = '{cyc + 1, 1'b1, m_cnt[18:0]}; aq.push_back(a);
            d = '{cyc + 3, wd}; wq.push_back(d);
        end
        if (erd) begin
            a = '{cyc + 1, 1'b0, ra}; aq.push_back(a);
            d = '{cyc + 4, rdfun(ra)}; rq.push_back(d);
        end
        if (erd && wait_w) begin
            if (m_streak < 3) m_streak++;
        end else if (aw || !wait_w) begin
            m_streak = 0;
        end
        if (s) begin
            m_st = 1; m_cnt = '0;
        end else if (aw) begin
            m_cnt = m_cnt + 1'b1;
            if (m_cnt == 20'(DEPTH)) m_st = 2;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [11:0] pat;
        int nw;
        bus.start = 0; bus.wr_valid = 0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", bus.zbt_we, 1'b0);
        chk("rst_addr", bus.zbt_addr, '0);
        chk("rst_wdata", bus.zbt_write_data, '0);
        chk("rst_rv", bus.rd_valid, 1'b0);
        chk("rst_rdata", bus.rd_data, '0);
        chk("rst_cnt", bus.wr_count, '0);
        chk("rst_done", bus.done, 1'b0);
        reset_n = 1'b1;

        // single write
        tick(1'b1, 1'b0, '0, 1'b0, '0);
        tick(1'b0, 1'b1, 36'h00001F47D, 1'b0, '0);
        idle(4);
        chk("w1_cnt", bus.wr_count, 1);

        // single read
        tick(1'b0, 1'b0, '0, 1'b1, 19'h00005);
        idle(6);

        // contention: 12 cycles of both requesting
        tick(1'b1, 1'b0, '0, 1'b0, '0);
        pat = '0; nw = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, pt_pack(12'(i + 1), 12'(3 * i), 12'hA5), 1'b1, 19'(100 + i));
            pat = {pat[10:0], g_rd};
            if (g_wacc) nw++;
        end
        chk("cont_pattern", pat, 12'hEEE);
        chk("cont_writes", nw, 3);
        idle(5);

        // fill to DEPTH, then one rejected write
        tick(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 36'(64'h100 + i), 1'b0, '0);
        chk("fill_done", bus.done, 1'b1);
        chk("fill_cnt", bus.wr_count, 4);
        tick(1'b0, 1'b1, 36'hFFFF, 1'b0, '0);
        idle(4);

        // start collides with a write mid-frame
        tick(1'b1, 1'b0, '0, 1'b0, '0);
        tick(1'b0, 1'b1, 36'h111, 1'b0, '0);
        tick(1'b0, 1'b1, 36'h222, 1'b0, '0);
        tick(1'b1, 1'b1, 36'h333, 1'b0, '0);
        tick(1'b0, 1'b1, 36'h444, 1'b0, '0);
        chk("coll_cnt", bus.wr_count, 1);
        idle(4);

        // reset while a write and a read are in flight
        tick(1'b0, 1'b0, '0, 1'b1, 19'h33);
        idle(2);
        tick(1'b0, 1'b1, 36'h9_8765_4321, 1'b0, '0);
        bus.wr_valid = 0; bus.rd_req = 0;
        #1;
        chk("pre_rst_we", bus.zbt_we, 1'b1);
        chk("pre_rst_rv", bus.rd_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", bus.zbt_we, 1'b0);
        chk("mid_rst_rv", bus.rd_valid, 1'b0);
        chk("mid_rst_wdata", bus.zbt_write_data, '0);
        aq.delete(); wq.delete(); rq.delete();
        last_addr = '0; last_wd = '0;
        m_st = 0; m_cnt = '0; m_streak = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(6);

        chk("q_empty", aq.size() + wq.size() + rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end

endmodule

// File: doc/zbt_point_arbiter.md
Name: zbt_point_arbiter

Overview:
- Owns the single ZBT SRAM port and shares it between two requesters:
  - Capture writer: packed 36-bit point records from the scan pipeline, auto-incrementing address.
  - Display reader: random-address reads.
- Hides the ZBT 2-cycle write-data / read-data pipeline from both requesters.
- Sits between the point-packing logic and the labkit ZBT driver.

Parameters:
- ADDR_W, 19, ZBT address width.
- DATA_W, 36, ZBT word width.
- DEPTH, 2**19, number of point slots in a capture frame.
- BASE_ADDR, 0, ZBT address of capture slot 0.
- MAX_RD_STREAK, 3, consecutive reader grants allowed while the writer waits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin new capture frame, write pointer to 0.
- wr_valid  in  1  writer has a point.
- wr_data  in  DATA_W  packed point record.
- wr_ready  out  1  writer handshake (combinational).
- rd_req  in  1  reader requests a read.
- rd_addr  in  ADDR_W  absolute ZBT read address.
- rd_ready  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  read data valid (registered).
- rd_data  out  DATA_W  read data (registered).
- wr_count  out  ADDR_W+1  points written in current frame.
- done  out  1  frame full.
- zbt_we  out  1  ZBT write enable, active-high; driver inverts it.
- zbt_addr  out  ADDR_W  ZBT address.
- zbt_write_data  out  DATA_W  ZBT write data.
- zbt_read_data  in  DATA_W  ZBT read data.

Behaviour:
- Reset (async, reset_n low):
  - Outputs: zbt_we=0, zbt_addr=0, zbt_write_data=0, rd_valid=0, rd_data=0, wr_count=0, done=0.
  - State IDLE; all pipeline stages and the streak counter cleared immediately.
  - In-flight operations are discarded.
- States:
  - IDLE -start-> CAPTURE.
  - CAPTURE -accept with wr_count==DEPTH-1-> FULL.
  - CAPTURE/FULL -start-> CAPTURE; wr_count=0, done=0.
  - done=1 only in FULL.
- Grant (combinational, per cycle):
  - force_wr = wr_valid && CAPTURE && streak==MAX_RD_STREAK.
  - rd_ready = rd_req && !force_wr.
  - wr_ready = CAPTURE && !start && !rd_ready.
  - At most one handshake per cycle. The reader wins by default.
- Streak counter:
  - Increments on a reader grant while wr_valid && CAPTURE.
  - Clears on a writer accept, or on any cycle where the writer is not waiting.
  - Saturates at MAX_RD_STREAK.
- Start collision: start in the same cycle as wr_valid means no write is accepted; start wins.
- Timing, for an accept on the edge ending cycle t:
  - Cycle t+1: zbt_addr and zbt_we registered valid.
    - Write: zbt_addr = BASE_ADDR + wr_count (width ADDR_W, wraps modulo 2**ADDR_W), zbt_we=1.
    - Read: zbt_addr = rd_addr, zbt_we=0.
  - Cycle t+3: zbt_write_data = the accepted wr_data. Write data is delayed exactly 2 cycles behind its address.
  - Read data: zbt_read_data sampled at the end of t+3; rd_valid=1 and rd_data valid during t+4, high for exactly one cycle.
  - Read latency is 4 cycles.
- wr_count increments on each accept, reaching at most DEPTH.
- Idle cycles: zbt_we=0, zbt_addr holds its last value, zbt_write_data holds its last value.
- Throughput: one operation per cycle, back-to-back, any read/write mix. No turnaround bubbles, since ZBT has none.
- start mid-frame: already-accepted writes still complete through the pipeline. New writes restart at BASE_ADDR.

Decomposition:
- Shared package zbt_pkg:
  - ZBT_ADDR_W=19, ZBT_DATA_W=36, ZBT_LAT=2.
  - State encoding IDLE/CAPTURE/FULL.
  - Point record field offsets (x, y, depth).
- Sub-module zbt_pipe_delay: parameterised shift register of depth ZBT_LAT with async active-low reset.
  - One instance carries {is_write, data}.
  - One instance carries the read tag.

Test Plan:
- Reset, start, then wr_valid with wr_data=36'h00001F47D for 1 cycle -> zbt_addr=0, zbt_we=1 at t+1; zbt_write_data=36'h00001F47D at t+3; wr_count=1.
- Read: rd_req, rd_addr=19'h00005; ZBT model returns 36'hABCDE0123 -> rd_ready=1 at t; rd_valid=1 with rd_data=36'hABCDE0123 exactly at t+4, for one cycle.
- Contention: rd_req and wr_valid held high for 12 cycles, MAX_RD_STREAK=3 -> grant pattern R,R,R,W repeating; exactly 3 writes accepted; write addresses 0,1,2 appear in order.
- Fill: DEPTH=4, four writes -> done=1 after the 4th accept; wr_count=4; wr_ready=0 afterwards; a 5th wr_valid causes no zbt_we.
- Start collision mid-frame: start together with wr_valid after 2 writes -> no accept that cycle; the next write goes to BASE_ADDR+0; wr_count=1.
- Reset mid-op: reset_n low one cycle after a write accept -> zbt_we=0 and rd_valid=0 immediately; no zbt_write_data update after reset.
